// File: rtl/flux_rr_scheduler.sv
// Round-robin scheduler that time-shares one tagged combinational actor
// between FLUX dataflow fluxes, granting each up to QUANTUM tokens in turn.
module flux_rr_scheduler #(
    parameter int FLUX      = 2,
    parameter int QUANTUM   = 4,
    parameter int TAG_WIDTH = $clog2(FLUX),
    parameter int CNT_WIDTH = $clog2(QUANTUM + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLUX-1:0]      empty,
    input  logic [FLUX-1:0]      full,
    input  logic [FLUX-1:0]      enable,
    output logic [TAG_WIDTH-1:0] tag,
    output logic                 tag_valid,
    output logic                 fire,
    output logic [FLUX-1:0]      read,
    output logic [FLUX-1:0]      write
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t                 state, state_n;
    logic [TAG_WIDTH-1:0]   tag_n;
    logic [TAG_WIDTH-1:0]   ptr, ptr_n;
    logic [CNT_WIDTH-1:0]   count, count_n;
    logic [FLUX-1:0]        req;
    logic [FLUX-1:0]        pick_vec;
    logic [TAG_WIDTH-1:0]   pick_start;
    logic [TAG_WIDTH:0]     pick_res;
    logic                   pick_found;
    logic [TAG_WIDTH-1:0]   pick_idx;

    // Index following t, wrapping FLUX-1 back to 0.
    function automatic logic [TAG_WIDTH-1:0] next_idx(input logic [TAG_WIDTH-1:0] t);
        return (t == TAG_WIDTH'(FLUX - 1)) ? '0 : t + 1'b1;
    endfunction

    // Rotating search: first set bit of vec walking start, start+1, ... mod FLUX.
    // Result is {found, index}.
    function automatic logic [TAG_WIDTH:0] rr_pick(input logic [FLUX-1:0]      vec,
                                                   input logic [TAG_WIDTH-1:0] start);
        logic                 found;
        logic [TAG_WIDTH-1:0] idx;
        int                   j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < FLUX; k++) begin
            j = (int'(start) + k) % FLUX;
            if (!found && vec[j]) begin
                found = 1'b1;
                idx   = TAG_WIDTH'(j);
            end
        end
        return {found, idx};
    endfunction

    // Request flags, strobes and the arbiter pick for this cycle.
    always_comb begin
        req       = enable & ~empty & ~full;
        tag_valid = (state == SERVE);
        fire      = tag_valid & req[tag];
        read      = fire ? (FLUX'(1) << tag) : '0;
        write     = read;
        // While serving, the arbiter restarts after the current tag and skips it
        // so another waiting flux gets the next grant.
        if (state == IDLE) begin
            pick_start = ptr;
            pick_vec   = req;
        end else begin
            pick_start = next_idx(tag);
            pick_vec   = req & ~(FLUX'(1) << tag);
        end
        pick_res   = rr_pick(pick_vec, pick_start);
        pick_found = pick_res[TAG_WIDTH];
        pick_idx   = pick_res[TAG_WIDTH-1:0];
    end

    // Next-state logic: grant, count tokens, release and rotate.
    always_comb begin
        state_n = state;
        tag_n   = tag;
        count_n = count;
        ptr_n   = ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = SERVE;
                    tag_n   = pick_idx;
                    count_n = '0;
                end
            end
            SERVE: begin
                if (fire && (count < CNT_WIDTH'(QUANTUM - 1))) begin
                    count_n = count + 1'b1;
                end else begin
                    // Quantum spent or current flux stalled: rotate the pointer.
                    ptr_n   = next_idx(tag);
                    count_n = '0;
                    if (pick_found) begin
                        tag_n = pick_idx;
                    end else if (!req[tag]) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tag   <= '0;
            count <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            tag   <= tag_n;
            count <= count_n;
            ptr   <= ptr_n;
        end
    end

endmodule
